// File: rtl/lsu_mem_master_if.sv
// Bundle of core request/response and word-memory signals for the LSU.
// The LSU drives through master; the core and memory side use slave.
interface lsu_mem_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_address;
    logic [31:0] req_write_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_error;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport master (
        input  req_valid, req_write, req_funct3,
        input  req_address, req_write_data,
        output req_ready,
        output resp_valid, resp_data, resp_error,
        input  resp_ready,
        output mem_write, mem_read,
        output mem_address, mem_write_data,
        input  mem_read_data
    );

    modport slave (
        output req_valid, req_write, req_funct3,
        output req_address, req_write_data,
        input  req_ready,
        input  resp_valid, resp_data, resp_error,
        output resp_ready,
        input  mem_write, mem_read,
        input  mem_address, mem_write_data,
        output mem_read_data
    );
endinterface

// File: rtl/lsu_mem_master.sv
// RV32 load/store unit driving a word-only memory; SB/SH go through
// read-modify-write since the memory has no byte enables.
module lsu_mem_master #(
    parameter int unsigned ADDR_LIMIT = 4096
) (
    input logic               clk,
    input logic               rst_n,
    lsu_mem_master_if.master  bus
);
    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPTURE,
        WRITE,
        RESP
    } state_e;

    state_e      state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        write_q, write_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        resp_error_q, resp_error_d;
    logic        mem_write_q, mem_write_d;
    logic        mem_read_q, mem_read_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic        f3_legal;
    logic        misaligned;
    logic [1:0]  size_m1;
    logic [32:0] end_addr;
    logic        out_of_range;
    logic        req_err;

    always_comb begin
        f3_legal = 1'b0;
        size_m1  = 2'd0;
        unique case (bus.req_funct3)
            3'b000, 3'b100: size_m1 = 2'd0;
            3'b001, 3'b101: size_m1 = 2'd1;
            default:        size_m1 = 2'd3;
        endcase
        if (bus.req_write) begin
            f3_legal = bus.req_funct3 inside {3'b000, 3'b001, 3'b010};
        end else begin
            f3_legal = bus.req_funct3 inside
                {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        end
        misaligned = (size_m1 == 2'd1 && bus.req_address[0])
                  || (size_m1 == 2'd3 && bus.req_address[1:0] != 2'b00);
        end_addr = {1'b0, bus.req_address} + {31'b0, size_m1};
        out_of_range = end_addr >= 33'(ADDR_LIMIT);
        req_err = !f3_legal || misaligned || out_of_range;
    end

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_val;
    logic [31:0] merged;

    // Lane selection uses the captured address, never the live request.
    always_comb begin
        rd_byte = bus.mem_read_data[{addr_q[1:0], 3'b000} +: 8];
        rd_half = bus.mem_read_data[{addr_q[1], 4'b0000} +: 16];
        unique case (funct3_q)
            3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
            3'b100:  load_val = {24'b0, rd_byte};
            3'b101:  load_val = {16'b0, rd_half};
            default: load_val = bus.mem_read_data;
        endcase
        merged = bus.mem_read_data;
        if (funct3_q == 3'b000) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    always_comb begin
        state_d       = state_q;
        write_d       = write_q;
        funct3_d      = funct3_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        resp_valid_d  = resp_valid_q;
        resp_data_d   = resp_data_q;
        resp_error_d  = resp_error_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    write_d  = bus.req_write;
                    funct3_d = bus.req_funct3;
                    addr_d   = bus.req_address;
                    wdata_d  = bus.req_write_data;
                    if (req_err) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                        resp_data_d  = 32'b0;
                    end else if (bus.req_write
                                 && bus.req_funct3 == 3'b010) begin
                        state_d       = WRITE;
                        mem_address_d = {bus.req_address[31:2], 2'b00};
                        mem_wdata_d   = bus.req_write_data;
                    end else begin
                        state_d       = READ;
                        mem_address_d = {bus.req_address[31:2], 2'b00};
                    end
                end
            end
            READ: state_d = CAPTURE;
            CAPTURE: begin
                if (write_q) begin
                    state_d     = WRITE;
                    mem_wdata_d = merged;
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_error_d = 1'b0;
                    resp_data_d  = load_val;
                end
            end
            WRITE: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_error_d = 1'b0;
                resp_data_d  = 32'b0;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        req_ready_d = state_d == IDLE;
        mem_read_d  = state_d == READ;
        mem_write_d = state_d == WRITE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            req_ready_q   <= 1'b1;
            write_q       <= 1'b0;
            funct3_q      <= 3'b0;
            addr_q        <= 32'b0;
            wdata_q       <= 32'b0;
            resp_valid_q  <= 1'b0;
            resp_data_q   <= 32'b0;
            resp_error_q  <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_address_q <= 32'b0;
            mem_wdata_q   <= 32'b0;
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            write_q       <= write_d;
            funct3_q      <= funct3_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            resp_valid_q  <= resp_valid_d;
            resp_data_q   <= resp_data_d;
            resp_error_q  <= resp_error_d;
            mem_write_q   <= mem_write_d;
            mem_read_q    <= mem_read_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

    assign bus.req_ready      = req_ready_q;
    assign bus.resp_valid     = resp_valid_q;
    assign bus.resp_data      = resp_data_q;
    assign bus.resp_error     = resp_error_q;
    assign bus.mem_write      = mem_write_q;
    assign bus.mem_read       = mem_read_q;
    assign bus.mem_address    = mem_address_q;
    assign bus.mem_write_data = mem_wdata_q;
endmodule
